// File: rtl/seg7_scan_driver_if.sv
// Write port of the 4-digit 7-segment scan driver: one-cycle store strobe
// carrying the four hex nibbles and the decimal-point enables.
interface seg7_scan_driver_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;

    modport master (output wr_en, output wr_data, output wr_dp);
    modport slave  (input  wr_en, input  wr_data, input  wr_dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered driver for a 4-digit active-low 7-segment display.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg7_scan_driver #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    seg7_scan_driver_if.slave        wr_bus,
    output logic [11:0]              BCD7,
    output logic                     frame_tick
);
    localparam int               DIV       = CLK_HZ / SCAN_HZ;
    localparam int               CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]    CNT_BLANK = CW'(BLANK_CYCLES);

    logic          run_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [3:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [11:0]   bcd7_q, bcd7_d;
    logic          tick_q, tick_d;
    logic [3:0]    nib;
    logic          hide;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        bcd7_d      = 12'hFFF;
        hide        = 1'b0;

        if (wr_bus.wr_en) begin
            pend_data_d = wr_bus.wr_data;
            pend_dp_d   = wr_bus.wr_dp;
        end

        // The edge leaving reset lands on (cnt 0, digit 0) rather than advancing past it.
        if (!run_q) begin
            cnt_d   = '0;
            digit_d = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
                act_data_d = pend_data_q;
                act_dp_d   = pend_dp_q;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        nib    = act_data_d[{digit_d, 2'b00} +: 4];
        tick_d = (cnt_d == '0) && (digit_d == 2'd0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (digit_d)
            2'd3:    hide = (act_data_d[15:12] == 4'h0);
            2'd2:    hide = (act_data_d[15:8]  == 8'h00);
            2'd1:    hide = (act_data_d[15:4]  == 12'h000);
            default: hide = 1'b0;
        endcase
`endif

        if (cnt_d >= CNT_BLANK && !hide)
            bcd7_d = {~(4'b0001 << digit_d), ~act_dp_d[digit_d], ~hex7(nib)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q       <= 1'b0;
            cnt_q       <= '0;
            digit_q     <= 2'd0;
            pend_data_q <= 16'h0000;
            pend_dp_q   <= 4'h0;
            act_data_q  <= 16'h0000;
            act_dp_q    <= 4'h0;
            bcd7_q      <= 12'hFFF;
            tick_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            run_q       <= 1'b1;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            bcd7_q      <= bcd7_d;
            tick_q      <= tick_d;
        end
    end

    assign BCD7       = bcd7_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: absolute-time reference model plus literal pins.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg7_scan_driver;
    localparam int CLK_HZ = 1000, SCAN_HZ = 100, BLANK = 2;
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int FRAME = 4 * DIV;
    localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [11:0] BCD7;
    logic frame_tick;
    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(rst), .wr_bus(bus), .BCD7(BCD7), .frame_tick(frame_tick));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    endtask

    // Reference model: m_t = cycles since the first edge after reset release.
    bit          m_run;
    int          m_t;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pend_dp, m_act_dp;
    logic [11:0] exp_bcd7;
    logic        exp_tick;

    function automatic logic [11:0] model_bcd7(int t, logic [15:0] d, logic [3:0] dp);
        int cnt = t % DIV;
        int dig = (t / DIV) % 4;
        int nib;
        logic [3:0] an;
        if (cnt < BLANK) return 12'hFFF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dig > 0 && (d >> (4 * dig)) == 16'h0) return 12'hFFF;
`endif
        nib = int'((d >> (4 * dig)) & 16'hF);
        an = 4'hF ^ (4'b0001 << dig);
        return {an, ~dp[dig], ~HEX7[nib]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_t <= 0;
            m_pend <= '0; m_pend_dp <= '0; m_act <= '0; m_act_dp <= '0;
        end else begin
            m_run <= 1'b1;
            m_t   <= m_run ? m_t + 1 : 0;
            if (bus.wr_en) begin
                m_pend <= bus.wr_data; m_pend_dp <= bus.wr_dp;
            end
            if (!m_run || (m_t + 1) % FRAME == 0) begin
                m_act <= m_pend; m_act_dp <= m_pend_dp;
            end
        end
    end

    always_comb begin
        exp_bcd7 = 12'hFFF;
        exp_tick = 1'b0;
        if (m_run) begin
            exp_bcd7 = model_bcd7(m_t, m_act, m_act_dp);
            exp_tick = (m_t % FRAME == 0);
        end
    end

    always @(negedge clk) begin
        check("cycle_bcd7", BCD7, exp_bcd7);
        check("cycle_tick", {11'b0, frame_tick}, {11'b0, exp_tick});
    end

    task automatic goto(input int target);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (m_run && m_t == target) return;
        end
        n_checks++;
        $display("FAIL goto_timeout: target t=%0d not reached, now t=%0d", target, m_t);
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] dp);
        @(negedge clk); #2;
        bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_dp = dp;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target, r;
        logic [15:0] d, mask;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_dp = '0;

        // 1: reset, release, guard window, frame tick period
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_bcd7", BCD7, 12'hFFF);
        check("reset_tick", {11'b0, frame_tick}, 12'h000);
        @(posedge clk); #1 rst = 1'b0;
        goto(0);
        check("first_tick", {11'b0, frame_tick}, 12'h001);
        check("first_blank0", BCD7, 12'hFFF);
        goto(1);
        check("first_blank1", BCD7, 12'hFFF);
        goto(2);
        check("first_digit0", BCD7, 12'hEC0);
        goto(40);
        check("tick_period", {11'b0, frame_tick}, 12'h001);
        goto(41);
        check("tick_pulse_end", {11'b0, frame_tick}, 12'h000);

        // 2: mid-frame write only visible from the next frame
        goto(45);
        write(16'h1234, 4'b0000);
        goto(52);
        check("old_frame_d1", BCD7, 12'hDC0);
        goto(82);
        check("new_frame_d0_lo", BCD7, 12'hE99);
        goto(89);
        check("new_frame_d0_hi", BCD7, 12'hE99);
        goto(92);
        check("new_frame_d1", BCD7, 12'hDB0);

        // 3: guard window and single anode
        goto(110);
        check("guard_d3", BCD7, 12'hFFF);
        goto(112);
        check("one_anode_low", 12'($countones(~BCD7[11:8])), 12'd1);

        // 4: write on the frame-boundary edge
        goto(158);
        write(16'hAAAA, 4'b0000);
        goto(162);
        check("boundary_old", BCD7, 12'hE99);
        goto(202);
        check("boundary_new_d0", BCD7, 12'hE88);
        goto(232);
        check("boundary_new_d3", BCD7, 12'h788);

        // randomized writes, checked every cycle by the model
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            r = $urandom_range(0, 3);
            mask = (r == 0) ? 16'h000F : (r == 1) ? 16'h00FF : (r == 2) ? 16'h0F0F : 16'hFFFF;
            d = 16'($urandom) & mask;
            write(d, 4'($urandom));
        end

        // 5: reset during digit 2
        @(negedge clk);
        target = (m_t / FRAME + 1) * FRAME + 25;
        goto(target);
        #2 rst = 1'b1;
        #1;
        check("midscan_reset_bcd7", BCD7, 12'hFFF);
        check("midscan_reset_tick", {11'b0, frame_tick}, 12'h000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        goto(0);
        check("restart_tick", {11'b0, frame_tick}, 12'h001);
        goto(2);
        check("restart_zero", BCD7, 12'hEC0);

        // 6: leading-zero handling with decimal point
        write(16'h0050, 4'b0001);
        goto(42);
        check("lz_d0_dp", BCD7, 12'hE40);
        goto(52);
        check("lz_d1", BCD7, 12'hD92);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        goto(62);
        check("lz_d2_blank", BCD7, 12'hFFF);
        goto(72);
        check("lz_d3_blank", BCD7, 12'hFFF);
`else
        goto(62);
        check("lz_d2_zero", BCD7, 12'hBC0);
        goto(72);
        check("lz_d3_zero", BCD7, 12'h7C0);
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
